fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised successor to the fixed-stage forwarding/stall unit.
- Keeps a per-register scoreboard of in-flight writers. Each entry has an age (cycles since issue) and a ready age (first age at which the result can be forwarded).
- Supports producers with any latency (ALU, load, long multi-cycle ops) and early-use consumers (branch/jr in decode).
- Sits beside the decode stage (s2). Drives stall_pipe plus forward-source selects for the s3 operand muxes and the decode-stage branch/jr comparators.

Parameters:
- REG_ADDR_LEFT, 4, MSB of register address; 2^(REG_ADDR_LEFT+1) entries.
- AGE_W, 4, width of the age and ready-age fields.
- RETIRE_AGE, 3, age at which the register-file write has completed (s3=age 0 ... s6=age 3). Must be < 2^AGE_W.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- r1_addr  in  REG_ADDR_LEFT+1  decode source 1
- r2_addr  in  REG_ADDR_LEFT+1  decode source 2
- early_use  in  1  decode instr reads operands in s2 (breq/brne/jreg)
- iss_valid  in  1  decode instr wants to advance to s3
- iss_rw  in  1  0 = issuing instr writes a register
- iss_waddr  in  REG_ADDR_LEFT+1  destination register
- iss_lat  in  AGE_W  ready age of the result: ALU=1, load=2, long op=N
- flush  in  1  kill the decode instr (no issue)
- stall_pipe  out  1  hold s1/s2, bubble into s3
- r1_fwd_en  out  1  registered; s3 operand 1 takes forwarded value
- r2_fwd_en  out  1  registered; s3 operand 2 takes forwarded value
- r1_fwd_age  out  AGE_W  registered; producer age while consumer is in s3 (1 = s4, 2 = s5, ...)
- r2_fwd_age  out  AGE_W  registered; as r1_fwd_age for operand 2
- b_r1_fwd_en  out  1  combinational; early-use forward enable, operand 1
- b_r2_fwd_en  out  1  combinational; early-use forward enable, operand 2
- b_r1_fwd_age  out  AGE_W  combinational; producer's current age, operand 1
- b_r2_fwd_age  out  AGE_W  combinational; producer's current age, operand 2
- stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Entry[r] = {valid, age, rdy}. Register 0 is never written to the table and never hits.
- Lookup is combinational on the current table. hitN = entry[rN_addr].valid && rN_addr != 0.
- Stall, normal consumer (early_use=0): hitN && rdy > age+1.
- Stall, early consumer (early_use=1): hitN && rdy > age.
- stall_pipe = iss_valid && !flush && (stall1 || stall2).
- iss_fire = iss_valid && !flush && !stall_pipe.
- Aging: every cycle, each valid entry does age <= age+1.
- Retirement: an entry clears on the edge where age == max(rdy, RETIRE_AGE). Long ops therefore hold their entry until their result is written back.
- Issue write: iss_fire && iss_rw==0 && iss_waddr!=0 sets entry[iss_waddr] <= {1, 0, iss_lat}.
  - This overrides aging and retirement for that register in the same cycle.
  - A newer writer replaces an older one (WAW: youngest wins).
- s3 selects: on iss_fire, r1_fwd_en <= hit1 && !early_use and r1_fwd_age <= age1+1; same for r2.
  - If the cycle is not a fire, both enables go to 0. The s3 slot then holds a bubble or a flushed instr.
- Early selects: b_rN_fwd_en = hitN && early_use && !stallN; b_rN_fwd_age = entry age.
- Ready value sources: an ALU result (rdy=1) forwards from s4. A load (rdy=2) forwards from s5.
- Resulting stalls: load-use stalls 1 cycle. Branch after ALU stalls 1 cycle. Branch/jr after load stalls 2 cycles.
- Flush: the decode instr is not issued and raises no stall. Table entries keep aging, since in-flight older instrs still complete.
- stall_count increments on each cycle with stall_pipe=1 and saturates at all-ones.
- Reset (rst_n=0 at clk edge): all entries invalid; every registered output = 0; stall_count = 0. Reset mid-operation drops all pending entries.

Test Plan:
- ALU writes r5 (lat 1), next instr is add reading r5 -> no stall; next cycle r1_fwd_en=1, r1_fwd_age=1.
- Load r5 (lat 2), next instr reads r5 as r2 -> stall_pipe=1 for exactly 1 cycle; then r2_fwd_en=1, r2_fwd_age=2; stall_count=1.
- Load r7 followed by beq with r1_addr=7 -> stall 2 cycles; third cycle b_r1_fwd_en=1, b_r1_fwd_age=2.
- Long op to r9 (lat 6), then consumer of r9 -> 5 stall cycles; on release r1_fwd_age=6; entry clears at age 6, not at 3.
- Write to r0 with lat 2, then consumer of r0 -> no stall, no forward enables; two back-to-back writers to r4 -> consumer forwards from the younger (age 0 lookup, fwd_age=1).
- Load r3, then flush on the consumer -> no stall; assert rst_n=0 mid-long-op -> next consumer of the register sees no hit, and all outputs and stall_count are 0.

Source files
------------

// File: rtl/fwd_scoreboard_if.sv
// Decode-side bundle of the forwarding scoreboard: issue/lookup requests in,
// stall and forward-source selects out.
interface fwd_scoreboard_if #(
  parameter int REG_ADDR_LEFT = 4,
  parameter int AGE_W         = 4,
  parameter int CNT_W         = 32
);
  logic [REG_ADDR_LEFT:0] r1_addr;
  logic [REG_ADDR_LEFT:0] r2_addr;
  logic                   early_use;
  logic                   iss_valid;
  logic                   iss_rw;
  logic [REG_ADDR_LEFT:0] iss_waddr;
  logic [AGE_W-1:0]       iss_lat;
  logic                   flush;
  logic                   stall_pipe;
  logic                   r1_fwd_en;
  logic                   r2_fwd_en;
  logic [AGE_W-1:0]       r1_fwd_age;
  logic [AGE_W-1:0]       r2_fwd_age;
  logic                   b_r1_fwd_en;
  logic                   b_r2_fwd_en;
  logic [AGE_W-1:0]       b_r1_fwd_age;
  logic [AGE_W-1:0]       b_r2_fwd_age;
  logic [CNT_W-1:0]       stall_count;

  modport master (
    output r1_addr, r2_addr, early_use, iss_valid, iss_rw, iss_waddr, iss_lat, flush,
    input  stall_pipe, r1_fwd_en, r2_fwd_en, r1_fwd_age, r2_fwd_age,
           b_r1_fwd_en, b_r2_fwd_en, b_r1_fwd_age, b_r2_fwd_age, stall_count
  );

  modport slave (
    input  r1_addr, r2_addr, early_use, iss_valid, iss_rw, iss_waddr, iss_lat, flush,
    output stall_pipe, r1_fwd_en, r2_fwd_en, r1_fwd_age, r2_fwd_age,
           b_r1_fwd_en, b_r2_fwd_en, b_r1_fwd_age, b_r2_fwd_age, stall_count
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Per-register scoreboard of in-flight writers: ages each writer, stalls
// consumers whose producer is not yet forwardable, and selects forward sources.
module fwd_sb_entry #(
  parameter int AGE_W      = 4,
  parameter int RETIRE_AGE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [AGE_W-1:0] lat_i,
  output logic             vld_o,
  output logic [AGE_W-1:0] age_o,
  output logic [AGE_W-1:0] rdy_o
);
  localparam logic [AGE_W-1:0] RET = AGE_W'(RETIRE_AGE);

  logic             vld_q, vld_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [AGE_W-1:0] rdy_q, rdy_d;
  logic [AGE_W-1:0] end_age;

  // Long ops outlive the normal writeback point until their own result lands.
  assign end_age = (rdy_q > RET) ? rdy_q : RET;

  always_comb begin
    vld_d = vld_q;
    age_d = age_q;
    rdy_d = rdy_q;
    if (wr_i) begin
      vld_d = 1'b1;
      age_d = '0;
      rdy_d = lat_i;
    end else if (vld_q) begin
      if (age_q == end_age) begin
        vld_d = 1'b0;
        age_d = '0;
        rdy_d = '0;
      end else begin
        age_d = age_q + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      age_q <= '0;
      rdy_q <= '0;
    end else begin
      vld_q <= vld_d;
      age_q <= age_d;
      rdy_q <= rdy_d;
    end
  end

  assign vld_o = vld_q;
  assign age_o = age_q;
  assign rdy_o = rdy_q;
endmodule

module fwd_scoreboard #(
  parameter int REG_ADDR_LEFT = 4,
  parameter int AGE_W         = 4,
  parameter int RETIRE_AGE    = 3,
  parameter int CNT_W         = 32
) (
  input logic              clk,
  input logic              rst_n,
  fwd_scoreboard_if.slave  sb
);
  localparam int RA_W = REG_ADDR_LEFT + 1;
  localparam int NREG = 2 ** RA_W;

  logic [NREG-1:0]             ent_vld;
  logic [NREG-1:0][AGE_W-1:0]  ent_age;
  logic [NREG-1:0][AGE_W-1:0]  ent_rdy;
  logic [NREG-1:0]             ent_wr;

  logic [1:0][RA_W-1:0]  src_addr;
  logic [1:0]            hit;
  logic [1:0]            stall;
  logic [1:0][AGE_W-1:0] src_age;
  logic [1:0][AGE_W-1:0] src_rdy;
  logic                  stall_any;
  logic                  fire;

  logic [1:0]            fwd_en_q, fwd_en_d;
  logic [1:0][AGE_W-1:0] fwd_age_q, fwd_age_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  assign src_addr[0] = sb.r1_addr;
  assign src_addr[1] = sb.r2_addr;

  // Register 0 is hardwired: no entry is ever written for it.
  assign ent_wr[0] = 1'b0;
  for (genvar i = 1; i < NREG; i++) begin : g_wr
    assign ent_wr[i] = fire && !sb.iss_rw && (sb.iss_waddr == RA_W'(i));
  end

  for (genvar i = 0; i < NREG; i++) begin : g_ent
    fwd_sb_entry #(.AGE_W(AGE_W), .RETIRE_AGE(RETIRE_AGE)) u_ent (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_i  (ent_wr[i]),
      .lat_i (sb.iss_lat),
      .vld_o (ent_vld[i]),
      .age_o (ent_age[i]),
      .rdy_o (ent_rdy[i])
    );
  end

  // Early consumers read in s2, so they need the result one cycle sooner.
  always_comb begin
    hit     = '0;
    stall   = '0;
    src_age = '0;
    src_rdy = '0;
    for (int k = 0; k < 2; k++) begin
      hit[k]     = ent_vld[src_addr[k]] && (src_addr[k] != '0);
      src_age[k] = ent_age[src_addr[k]];
      src_rdy[k] = ent_rdy[src_addr[k]];
      if (sb.early_use)
        stall[k] = hit[k] && ({1'b0, src_rdy[k]} > {1'b0, src_age[k]});
      else
        stall[k] = hit[k] && ({1'b0, src_rdy[k]} > ({1'b0, src_age[k]} + (AGE_W+1)'(1)));
    end
  end

  assign stall_any = sb.iss_valid && !sb.flush && (stall[0] || stall[1]);
  assign fire      = sb.iss_valid && !sb.flush && !stall_any;

  always_comb begin
    fwd_en_d  = '0;
    fwd_age_d = '0;
    cnt_d     = cnt_q;
    for (int k = 0; k < 2; k++) begin
      if (fire && hit[k]) begin
        fwd_en_d[k]  = !sb.early_use;
        fwd_age_d[k] = src_age[k] + AGE_W'(1);
      end
    end
    if (stall_any && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_en_q  <= '0;
      fwd_age_q <= '0;
      cnt_q     <= '0;
    end else begin
      fwd_en_q  <= fwd_en_d;
      fwd_age_q <= fwd_age_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sb.stall_pipe   = stall_any;
  assign sb.r1_fwd_en    = fwd_en_q[0];
  assign sb.r2_fwd_en    = fwd_en_q[1];
  assign sb.r1_fwd_age   = fwd_age_q[0];
  assign sb.r2_fwd_age   = fwd_age_q[1];
  assign sb.b_r1_fwd_en  = hit[0] && sb.early_use && !stall[0];
  assign sb.b_r2_fwd_en  = hit[1] && sb.early_use && !stall[1];
  assign sb.b_r1_fwd_age = hit[0] ? src_age[0] : '0;
  assign sb.b_r2_fwd_age = hit[1] ? src_age[1] : '0;
  assign sb.stall_count  = cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed checks of the forwarding scoreboard: ALU/load/long-op forwarding,
// early-use stalls, r0, WAW, flush and mid-operation reset.
module tb_fwd_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fwd_scoreboard_if #(.REG_ADDR_LEFT(4), .AGE_W(4), .CNT_W(32)) sb ();

  fwd_scoreboard #(.REG_ADDR_LEFT(4), .AGE_W(4), .RETIRE_AGE(3), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb)
  );

  task automatic drv(input logic v, input logic rw, input logic [4:0] wa, input logic [3:0] lat,
                     input logic [4:0] a1, input logic [4:0] a2, input logic e, input logic f);
    sb.iss_valid = v;  sb.iss_rw = rw; sb.iss_waddr = wa; sb.iss_lat = lat;
    sb.r1_addr = a1;   sb.r2_addr = a2; sb.early_use = e; sb.flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drv(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (sb.stall_pipe !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", sb.stall_pipe); end
    n_cmp++; if (sb.r1_fwd_en !== 1'b0) begin n_err++; $display("FAIL rst_r1_en got %b want 0", sb.r1_fwd_en); end
    n_cmp++; if (sb.r2_fwd_en !== 1'b0) begin n_err++; $display("FAIL rst_r2_en got %b want 0", sb.r2_fwd_en); end
    n_cmp++; if (sb.r1_fwd_age !== 4'd0) begin n_err++; $display("FAIL rst_r1_age got %0d want 0", sb.r1_fwd_age); end
    n_cmp++; if (sb.r2_fwd_age !== 4'd0) begin n_err++; $display("FAIL rst_r2_age got %0d want 0", sb.r2_fwd_age); end
    n_cmp++; if (sb.stall_count !== 32'd0) begin n_err++; $display("FAIL rst_cnt got %0d want 0", sb.stall_count); end
    n_cmp++; if (sb.b_r1_fwd_en !== 1'b0) begin n_err++; $display("FAIL rst_b_r1_en got %b want 0", sb.b_r1_fwd_en); end
  endtask

  task automatic test_alu_fwd();
    apply_reset();
    drv(1, 0, 5, 1, 0, 0, 0, 0); tick();
    drv(1, 1, 0, 0, 5, 0, 0, 0); #1;
    n_cmp++; if (sb.stall_pipe !== 1'b0) begin n_err++; $display("FAIL alu_stall got %b want 0", sb.stall_pipe); end
    tick();
    n_cmp++; if (sb.r1_fwd_en !== 1'b1) begin n_err++; $display("FAIL alu_r1_en got %b want 1", sb.r1_fwd_en); end
    n_cmp++; if (sb.r1_fwd_age !== 4'd1) begin n_err++; $display("FAIL alu_r1_age got %0d want 1", sb.r1_fwd_age); end
    n_cmp++; if (sb.r2_fwd_en !== 1'b0) begin n_err++; $display("FAIL alu_r2_en got %b want 0", sb.r2_fwd_en); end
  endtask

  task automatic test_load_use();
    apply_reset();
    drv(1, 0, 5, 2, 0, 0, 0, 0); tick();
    drv(1, 1, 0, 0, 0, 5, 0, 0); #1;
    n_cmp++; if (sb.stall_pipe !== 1'b1) begin n_err++; $display("FAIL ld_stall0 got %b want 1", sb.stall_pipe); end
    tick();
    n_cmp++; if (sb.r2_fwd_en !== 1'b0) begin n_err++; $display("FAIL ld_bubble_en got %b want 0", sb.r2_fwd_en); end
    n_cmp++; if (sb.stall_pipe !== 1'b0) begin n_err++; $display("FAIL ld_stall1 got %b want 0", sb.stall_pipe); end
    tick();
    n_cmp++; if (sb.r2_fwd_en !== 1'b1) begin n_err++; $display("FAIL ld_r2_en got %b want 1", sb.r2_fwd_en); end
    n_cmp++; if (sb.r2_fwd_age !== 4'd2) begin n_err++; $display("FAIL ld_r2_age got %0d want 2", sb.r2_fwd_age); end
    n_cmp++; if (sb.stall_count !== 32'd1) begin n_err++; $display("FAIL ld_cnt got %0d want 1", sb.stall_count); end
  endtask

  task automatic test_branch_load();
    apply_reset();
    drv(1, 0, 7, 2, 0, 0, 0, 0); tick();
    drv(1, 1, 0, 0, 7, 0, 1, 0); #1;
    n_cmp++; if (sb.stall_pipe !== 1'b1) begin n_err++; $display("FAIL br_stall0 got %b want 1", sb.stall_pipe); end
    tick();
    n_cmp++; if (sb.stall_pipe !== 1'b1) begin n_err++; $display("FAIL br_stall1 got %b want 1", sb.stall_pipe); end
    n_cmp++; if (sb.b_r1_fwd_en !== 1'b0) begin n_err++; $display("FAIL br_b_en_early got %b want 0", sb.b_r1_fwd_en); end
    tick();
    n_cmp++; if (sb.stall_pipe !== 1'b0) begin n_err++; $display("FAIL br_stall2 got %b want 0", sb.stall_pipe); end
    n_cmp++; if (sb.b_r1_fwd_en !== 1'b1) begin n_err++; $display("FAIL br_b_en got %b want 1", sb.b_r1_fwd_en); end
    n_cmp++; if (sb.b_r1_fwd_age !== 4'd2) begin n_err++; $display("FAIL br_b_age got %0d want 2", sb.b_r1_fwd_age); end
    n_cmp++; if (sb.stall_count !== 32'd2) begin n_err++; $display("FAIL br_cnt got %0d want 2", sb.stall_count); end
    tick();
    n_cmp++; if (sb.r1_fwd_en !== 1'b0) begin n_err++; $display("FAIL br_s3_en got %b want 0", sb.r1_fwd_en); end
  endtask

  task automatic test_long_op();
    apply_reset();
    drv(1, 0, 9, 6, 0, 0, 0, 0); tick();
    drv(1, 1, 0, 0, 9, 0, 0, 0); #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (sb.stall_pipe !== 1'b1) begin n_err++; $display("FAIL long_stall[%0d] got %b want 1", i, sb.stall_pipe); end
      tick();
    end
    n_cmp++; if (sb.stall_pipe !== 1'b0) begin n_err++; $display("FAIL long_release got %b want 0", sb.stall_pipe); end
    tick();
    n_cmp++; if (sb.r1_fwd_en !== 1'b1) begin n_err++; $display("FAIL long_r1_en got %b want 1", sb.r1_fwd_en); end
    n_cmp++; if (sb.r1_fwd_age !== 4'd6) begin n_err++; $display("FAIL long_r1_age got %0d want 6", sb.r1_fwd_age); end
    n_cmp++; if (sb.stall_count !== 32'd5) begin n_err++; $display("FAIL long_cnt got %0d want 5", sb.stall_count); end
    // Probe with an early-use lookup: entry must still be alive at age 6.
    drv(0, 1, 0, 0, 9, 0, 1, 0); #1;
    n_cmp++; if (sb.b_r1_fwd_en !== 1'b1) begin n_err++; $display("FAIL long_alive6 got %b want 1", sb.b_r1_fwd_en); end
    n_cmp++; if (sb.b_r1_fwd_age !== 4'd6) begin n_err++; $display("FAIL long_age6 got %0d want 6", sb.b_r1_fwd_age); end
    tick();
    n_cmp++; if (sb.b_r1_fwd_en !== 1'b0) begin n_err++; $display("FAIL long_retired got %b want 0", sb.b_r1_fwd_en); end
  endtask

  task automatic test_r0_waw();
    apply_reset();
    drv(1, 0, 0, 2, 0, 0, 0, 0); tick();
    drv(1, 1, 0, 0, 0, 0, 0, 0); #1;
    n_cmp++; if (sb.stall_pipe !== 1'b0) begin n_err++; $display("FAIL r0_stall got %b want 0", sb.stall_pipe); end
    tick();
    n_cmp++; if ({sb.r1_fwd_en, sb.r2_fwd_en} !== 2'b00) begin n_err++; $display("FAIL r0_en got %b want 00", {sb.r1_fwd_en, sb.r2_fwd_en}); end
    drv(1, 0, 4, 2, 0, 0, 0, 0); tick();
    drv(1, 0, 4, 1, 0, 0, 0, 0); #1;
    n_cmp++; if (sb.stall_pipe !== 1'b0) begin n_err++; $display("FAIL waw_stall_w got %b want 0", sb.stall_pipe); end
    tick();
    drv(1, 1, 0, 0, 4, 4, 0, 0); #1;
    n_cmp++; if (sb.stall_pipe !== 1'b0) begin n_err++; $display("FAIL waw_stall_c got %b want 0", sb.stall_pipe); end
    tick();
    n_cmp++; if (sb.r1_fwd_en !== 1'b1) begin n_err++; $display("FAIL waw_r1_en got %b want 1", sb.r1_fwd_en); end
    n_cmp++; if (sb.r1_fwd_age !== 4'd1) begin n_err++; $display("FAIL waw_r1_age got %0d want 1", sb.r1_fwd_age); end
    n_cmp++; if (sb.r2_fwd_age !== 4'd1) begin n_err++; $display("FAIL waw_r2_age got %0d want 1", sb.r2_fwd_age); end
  endtask

  task automatic test_flush_reset();
    apply_reset();
    drv(1, 0, 3, 2, 0, 0, 0, 0); tick();
    drv(1, 1, 0, 0, 3, 0, 0, 1); #1;
    n_cmp++; if (sb.stall_pipe !== 1'b0) begin n_err++; $display("FAIL fl_stall got %b want 0", sb.stall_pipe); end
    tick();
    n_cmp++; if (sb.r1_fwd_en !== 1'b0) begin n_err++; $display("FAIL fl_r1_en got %b want 0", sb.r1_fwd_en); end
    n_cmp++; if (sb.stall_count !== 32'd0) begin n_err++; $display("FAIL fl_cnt got %0d want 0", sb.stall_count); end
    drv(1, 1, 0, 0, 3, 0, 0, 0); tick();
    n_cmp++; if (sb.r1_fwd_age !== 4'd2) begin n_err++; $display("FAIL fl_aged got %0d want 2", sb.r1_fwd_age); end
    drv(1, 0, 9, 6, 0, 0, 0, 0); tick();
    drv(1, 1, 0, 0, 9, 0, 0, 0); tick(); tick();
    n_cmp++; if (sb.stall_count !== 32'd2) begin n_err++; $display("FAIL mid_cnt got %0d want 2", sb.stall_count); end
    apply_reset();
    n_cmp++; if (sb.stall_count !== 32'd0) begin n_err++; $display("FAIL mid_rst_cnt got %0d want 0", sb.stall_count); end
    n_cmp++; if ({sb.r1_fwd_en, sb.r1_fwd_age} !== 5'd0) begin n_err++; $display("FAIL mid_rst_fwd got %h want 0", {sb.r1_fwd_en, sb.r1_fwd_age}); end
    drv(1, 1, 0, 0, 9, 0, 1, 0); #1;
    n_cmp++; if (sb.stall_pipe !== 1'b0) begin n_err++; $display("FAIL mid_rst_stall got %b want 0", sb.stall_pipe); end
    n_cmp++; if (sb.b_r1_fwd_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_b_en got %b want 0", sb.b_r1_fwd_en); end
    drv(1, 1, 0, 0, 9, 0, 0, 0); tick();
    n_cmp++; if (sb.r1_fwd_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_s3_en got %b want 0", sb.r1_fwd_en); end
  endtask

  initial begin
    drv(0, 1, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_branch_load();
    test_long_op();
    test_r0_waw();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
